// File: rtl/isp_1bit_dilation_pkg.sv
// Shared types and constants for the 1-bit ISP morphology stages.
package isp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_FLUSH
   } dil_state_e;

   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_BLACK = 16'h0000;

   function automatic int unsigned col_width(input int unsigned img_w);
      return (img_w > 1) ? $clog2(img_w) : 1;
   endfunction

   function automatic int unsigned row_width(input int unsigned img_h);
      return (img_h > 1) ? $clog2(img_h) : 1;
   endfunction

endpackage

// File: rtl/isp_1bit_dilation_if.sv
// Pixel-in / dilated-pixel-out stream bundle; the dilation block is the slave.
interface isp_1bit_dilation_if;
   import isp_pkg::*;

   logic        wr_en;
   logic        img_1bit_in;
   logic        dilation_wr_en;
   logic        img_1bit_out;
   logic [15:0] dilation_rgb565;
   logic        err_drop;

   modport master (
      output wr_en, img_1bit_in,
      input  dilation_wr_en, img_1bit_out, dilation_rgb565, err_drop
   );

   modport slave (
      input  wr_en, img_1bit_in,
      output dilation_wr_en, img_1bit_out, dilation_rgb565, err_drop
   );

endinterface

// File: rtl/isp_1bit_dilation_window.sv
// Two line buffers plus a 3x3 shift window; win[0] is the oldest row, win[*][2] the newest column.
module dilation_window_1bit
   import isp_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned COL_W = col_width(IMG_W)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             adv,
   input  logic [COL_W-1:0] col,
   input  logic             pix,
   output logic [2:0][2:0]  win
);

   logic            lb0 [IMG_W];
   logic            lb1 [IMG_W];
   logic            lb0_rd, lb1_rd;
   logic [2:0][2:0] win_q;

   assign lb0_rd = lb0[col];
   assign lb1_rd = lb1[col];
   assign win    = win_q;

   // Line RAM is deliberately not reset; border masking hides stale contents.
   always_ff @(posedge sys_clk) begin
      if (adv) begin
         lb1[col] <= lb0_rd;
         lb0[col] <= pix;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         win_q <= '0;
      end else if (adv) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb1_rd;
         win_q[1][2] <= lb0_rd;
         win_q[2][2] <= pix;
      end
   end

endmodule

// File: rtl/isp_1bit_dilation.sv
// 3x3 binary dilation over a raster 1-bit stream with border masking and an end-of-frame
// flush, so each frame yields exactly IMG_W*IMG_H output beats.
module isp_1bit_dilation
   import isp_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input logic                sys_clk,
   input logic                sys_rst_n,
   isp_1bit_dilation_if.slave bus
);

   localparam int unsigned      COL_W    = col_width(IMG_W);
   localparam int unsigned      ROW_W    = row_width(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   dil_state_e       state_q, state_d;
   logic [COL_W-1:0] in_col_q, c_col_q;
   logic [ROW_W-1:0] in_row_q, c_row_q;
   logic             in_flush, adv, emit, last_in, last_c, fill_done;
   logic [2:0][2:0]  win;
   logic             v0_q, v1_q, v2_q;
   logic             m_left_q, m_right_q, m_top_q, m_bot_q;
   logic [2:0]       row_or, s1_q;
   logic             out_q, err_q;

   assign in_flush  = (state_q == ST_FLUSH);
   assign adv       = bus.wr_en | in_flush;
   assign emit      = (state_q == ST_RUN && bus.wr_en) || in_flush;
   assign last_in   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
   assign last_c    = (c_row_q == ROW_LAST) && (c_col_q == COL_LAST);
   assign fill_done = (in_row_q == ROW_W'(1)) && (in_col_q == '0);

   // Flush ticks feed zeros; a stray wr_en in FLUSH is absorbed as an ordinary tick.
   dilation_window_1bit #(
      .IMG_W (IMG_W),
      .COL_W (COL_W)
   ) u_window (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .adv       (adv),
      .col       (in_col_q),
      .pix       (bus.img_1bit_in & ~in_flush),
      .win       (win)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.wr_en) state_d = ST_FILL;
         ST_FILL:  if (bus.wr_en && fill_done) state_d = ST_RUN;
         ST_RUN:   if (bus.wr_en && last_in) state_d = ST_FLUSH;
         ST_FLUSH: if (last_c) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (in_flush && bus.wr_en) err_q <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         in_col_q <= '0;
         in_row_q <= '0;
         c_col_q  <= '0;
         c_row_q  <= '0;
      end else if (in_flush && last_c) begin
         in_col_q <= '0;
         in_row_q <= '0;
         c_col_q  <= '0;
         c_row_q  <= '0;
      end else begin
         if (adv) begin
            if (in_col_q == COL_LAST) begin
               in_col_q <= '0;
               in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_W'(1);
            end else begin
               in_col_q <= in_col_q + COL_W'(1);
            end
         end
         if (emit) begin
            if (c_col_q == COL_LAST) begin
               c_col_q <= '0;
               c_row_q <= (c_row_q == ROW_LAST) ? '0 : c_row_q + ROW_W'(1);
            end else begin
               c_col_q <= c_col_q + COL_W'(1);
            end
         end
      end
   end

   // Masks are captured alongside the window shift so they line up with its centre.
   always_comb begin
      row_or = '0;
      for (int r = 0; r < 3; r++) begin
         row_or[r] = (win[r][0] & ~m_left_q) | win[r][1] | (win[r][2] & ~m_right_q);
      end
      if (m_top_q) row_or[0] = 1'b0;
      if (m_bot_q) row_or[2] = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         m_left_q  <= 1'b0;
         m_right_q <= 1'b0;
         m_top_q   <= 1'b0;
         m_bot_q   <= 1'b0;
         s1_q      <= '0;
         out_q     <= 1'b0;
      end else begin
         v0_q      <= emit;
         m_left_q  <= (c_col_q == '0);
         m_right_q <= (c_col_q == COL_LAST);
         m_top_q   <= (c_row_q == '0);
         m_bot_q   <= (c_row_q == ROW_LAST);
         v1_q      <= v0_q;
         s1_q      <= v0_q ? row_or : '0;
         v2_q      <= v1_q;
         out_q     <= v1_q & (|s1_q);
      end
   end

   assign bus.dilation_wr_en  = v2_q;
   assign bus.img_1bit_out    = out_q;
   assign bus.dilation_rgb565 = out_q ? RGB565_WHITE : RGB565_BLACK;
   assign bus.err_drop        = err_q;

endmodule

// File: tb/tb_isp_1bit_dilation.sv
// Bench for isp_1bit_dilation: directed and random frames scored against a neighbourhood-OR model.
module tb_isp_1bit_dilation;

   localparam int W      = 8;
   localparam int H      = 4;
   localparam int NF     = 16;
   localparam int PERIOD = 10;

   typedef struct {
      bit pix;
      int fid;
      int r;
      int c;
   } exp_t;

   logic   sys_clk;
   logic   sys_rst_n;
   bit     img [H][W];
   exp_t   exp_q[$];
   exp_t   mon_e;
   int     frame_out [NF];
   bit     aborted [NF];
   longint t_beat9 [NF];
   longint t_first [NF];
   int     n_tests;
   int     n_fail;
   int     n_frames;

   isp_1bit_dilation_if bus ();

   isp_1bit_dilation #(
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial sys_clk = 1'b0;
   always #(PERIOD / 2) sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: OR over the in-frame part of the 3x3 neighbourhood.
   function automatic bit model_px(input int r, input int c);
      bit o = 1'b0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) o |= img[r + dr][c + dc];
         end
      end
      return o;
   endfunction

   task automatic set_fill(input bit v);
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic set_random(input int dens);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = ($urandom_range(0, 99) < dens);
   endtask

   // Drives one frame; stop_at >= 0 ends the frame early after that beat.
   task automatic run_frame(input bit gaps, input int blank, input int pulse_at,
                            input int stop_at);
      int fid = n_frames;
      n_frames++;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            exp_q.push_back('{pix: model_px(r, c), fid: fid, r: r, c: c});
      for (int k = 0; k < W * H; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.wr_en = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge sys_clk);
            #1;
         end
         bus.wr_en       = 1'b1;
         bus.img_1bit_in = img[k / W][k % W];
         @(posedge sys_clk);
         if (k == 9) t_beat9[fid] = $time;
         #1;
         if (k == stop_at) break;
      end
      bus.wr_en       = 1'b0;
      bus.img_1bit_in = 1'b0;
      if (stop_at >= 0) begin
         aborted[fid] = 1'b1;
         return;
      end
      for (int i = 0; i < blank; i++) begin
         bus.wr_en       = (i == pulse_at);
         bus.img_1bit_in = (i == pulse_at);
         @(posedge sys_clk);
         #1;
      end
      bus.wr_en       = 1'b0;
      bus.img_1bit_in = 1'b0;
   endtask

   always @(negedge sys_clk) begin
      if (bus.dilation_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq($sformatf("pix f%0d r%0d c%0d", mon_e.fid, mon_e.r, mon_e.c),
                     32'(bus.img_1bit_out), 32'(mon_e.pix));
            check_eq("rgb565", 32'(bus.dilation_rgb565), mon_e.pix ? 32'hFFFF : 32'h0);
            if (frame_out[mon_e.fid] == 0) t_first[mon_e.fid] = $time;
            frame_out[mon_e.fid]++;
         end
      end else begin
         check_eq("idle_pixel", 32'(bus.img_1bit_out), 32'd0);
         check_eq("idle_rgb565", 32'(bus.dilation_rgb565), 32'd0);
      end
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      n_frames = 0;
      for (int f = 0; f < NF; f++) begin
         frame_out[f] = 0;
         aborted[f]   = 1'b0;
         t_beat9[f]   = 0;
         t_first[f]   = 0;
      end
      sys_rst_n       = 1'b0;
      bus.wr_en       = 1'b0;
      bus.img_1bit_in = 1'b0;
      repeat (2) @(negedge sys_clk);
      check_eq("rst_valid", 32'(bus.dilation_wr_en), 32'd0);
      check_eq("rst_err", 32'(bus.err_drop), 32'd0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Isolated pixels, including corners and the right edge.
      set_fill(1'b0); img[1][3] = 1'b1; run_frame(1'b0, 12, -1, -1);
      set_fill(1'b0); img[0][0] = 1'b1; run_frame(1'b0, 12, -1, -1);
      set_fill(1'b0); img[2][7] = 1'b1; run_frame(1'b0, 12, -1, -1);

      // Minimum blanking between an all-0 and an all-1 frame.
      set_fill(1'b0); run_frame(1'b0, W + 1, -1, -1);
      set_fill(1'b1); run_frame(1'b0, 12, -1, -1);

      // Stray beat during flush is dropped and latches err_drop.
      set_random(50); run_frame(1'b0, 12, 3, -1);
      check_eq("err_set", 32'(bus.err_drop), 32'd1);
      set_random(10); run_frame(1'b0, 12, -1, -1);
      check_eq("err_sticky", 32'(bus.err_drop), 32'd1);

      // Reset in the middle of RUN abandons the frame.
      set_random(20); run_frame(1'b0, 0, -1, 15);
      sys_rst_n = 1'b0;
      exp_q.delete();
      repeat (3) begin
         @(negedge sys_clk);
         check_eq("mid_rst_valid", 32'(bus.dilation_wr_en), 32'd0);
         check_eq("mid_rst_pixel", 32'(bus.img_1bit_out), 32'd0);
         check_eq("mid_rst_err", 32'(bus.err_drop), 32'd0);
      end
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      set_fill(1'b0); img[3][0] = 1'b1; run_frame(1'b0, 12, -1, -1);

      // Random sparse frames with input gaps.
      for (int i = 0; i < 5; i++) begin
         set_random(5 + 7 * i);
         run_frame(1'b1, 12, -1, -1);
      end

      repeat (20) @(posedge sys_clk);
      #1;
      for (int f = 0; f < n_frames; f++) begin
         if (!aborted[f]) begin
            check_eq($sformatf("out_count f%0d", f), 32'(frame_out[f]), 32'(W * H));
            check_eq($sformatf("latency f%0d", f), 32'(t_first[f] - t_beat9[f]),
                     32'(2 * PERIOD + PERIOD / 2));
         end
      end
      check_eq("exp_left", 32'(exp_q.size()), 32'd0);
      check_eq("err_final", 32'(bus.err_drop), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
